lsu_mem_stage: RTL and testbench

Load/store unit for the RV32I core's memory-access stage. It sits directly downstream of the ALU: the ALU result (the ADD path for loads and stores) is taken as the effective address, and the unit runs a request/acknowledge transaction on the data-memory port. It steers byte lanes for SB/SH/SW, and extracts and sign- or zero-extends LB/LH/LW/LBU/LHU data for writeback. The pipeline stalls through `ex_ready` while a transaction is outstanding.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu_mem_stage.sv | 119 +++++++++++
 tb/tb_lsu_mem_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings and the LSU state enum.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads; purely combinational.
// Zero latency, no flow control; unsupported funct3 values produce no byte enables.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {offset, 3'b000};
    assign wdata   = store_data << shamt;
    assign shifted = rdata >> shamt;

    always_comb begin
        be        = 4'b0000;
        load_data = shifted;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << offset;
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                be        = 4'b0001 << offset;
                load_data = {24'h0, shifted[7:0]};
            end
            F3_H: begin
                be        = 4'b0011 << offset;
                load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                be        = 4'b0011 << offset;
                load_data = {16'h0, shifted[15:0]};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I memory stage: one req/ack transaction per op, done 1 cycle after ack; ex_ready low while busy.
// LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of masking the low address bits.
module lsu_mem_stage
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              done,
    output logic [31:0]       wb_data,
    output logic              misalign
);

    lsu_state_t  state, state_nxt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        accept, is_half, is_word, trap;
    logic [1:0]  off_eff;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;

    assign accept  = ex_valid & ex_ready & (ex_mem_read | ex_mem_write);
    assign is_half = (ex_funct3 == F3_H) || (ex_funct3 == F3_HU);
    assign is_word = (ex_funct3 == F3_W);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap    = (is_half & ex_addr[0]) | (is_word & (|ex_addr[1:0]));
    assign off_eff = ex_addr[1:0];
`else
    assign trap    = 1'b0;
    assign off_eff = is_word ? 2'b00 : (is_half ? {ex_addr[1], 1'b0} : ex_addr[1:0]);
    assign misalign = 1'b0;
`endif

    // The aligner serves the store path while idle and the load path while a request is pending.
    assign al_f3  = (state == LSU_IDLE) ? ex_funct3 : f3_q;
    assign al_off = (state == LSU_IDLE) ? off_eff   : off_q;

    lsu_align u_align (
        .funct3     (al_f3),
        .offset     (al_off),
        .store_data (ex_store_data),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    always_comb begin
        state_nxt = state;
        ex_ready  = 1'b0;
        dmem_req  = 1'b0;
        done      = 1'b0;
        case (state)
            LSU_IDLE: begin
                ex_ready = 1'b1;
                if (accept) state_nxt = trap ? LSU_RESP : LSU_REQ;
            end
            LSU_REQ: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                done      = 1'b1;
                state_nxt = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LSU_IDLE;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'b0000;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            wb_data    <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign <= accept & trap;
`endif
            if (accept && !trap) begin
                dmem_addr  <= {ex_addr[31:2], 2'b00};
                dmem_we    <= ex_mem_write;
                dmem_be    <= al_be;
                dmem_wdata <= al_wdata;
                f3_q       <= ex_funct3;
                off_q      <= off_eff;
            end
            if (state == LSU_REQ && dmem_ack && !dmem_we)
                wb_data <= al_load;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: hand-computed request fields, timing and writeback values.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        done, misalign;
    logic [31:0] wb_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_be       (dmem_be),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .done          (done),
        .wb_data       (wb_data),
        .misalign      (misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic mem_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                          input int delay, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        check({tag, ".ready_pre"}, 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
        ex_funct3 = f3; ex_addr = addr; ex_store_data = sdata;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_addr = 32'hFFFF_FFFF; ex_store_data = 32'h5555_5555; ex_funct3 = 3'b111;
        @(negedge clk);
        check({tag, ".req"},   32'(dmem_req), 32'd1);
        check({tag, ".we"},    32'(dmem_we), 32'(wr));
        check({tag, ".addr"},  dmem_addr, exp_addr);
        check({tag, ".be"},    32'(dmem_be), 32'(exp_be));
        check({tag, ".wdata"}, dmem_wdata, exp_wdata);
        check({tag, ".busy"},  32'(ex_ready), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, ".req_hold"},   32'(dmem_req), 32'd1);
            check({tag, ".addr_hold"},  dmem_addr, exp_addr);
            check({tag, ".be_hold"},    32'(dmem_be), 32'(exp_be));
            check({tag, ".wdata_hold"}, dmem_wdata, exp_wdata);
            check({tag, ".busy_hold"},  32'(ex_ready), 32'd0);
            check({tag, ".done_early"}, 32'(done), 32'd0);
        end
        dmem_ack = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check({tag, ".done"},     32'(done), 32'd1);
        check({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
        check({tag, ".resp_busy"}, 32'(ex_ready), 32'd0);
        check({tag, ".wb"},       wb_data, exp_wb);
        @(negedge clk);
        check({tag, ".done_1cyc"}, 32'(done), 32'd0);
        check({tag, ".wb_hold"},   wb_data, exp_wb);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = 3'b000; ex_addr = 32'h0; ex_store_data = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst.ready", 32'(ex_ready), 32'd1);
        check("rst.req",   32'(dmem_req), 32'd0);
        check("rst.we",    32'(dmem_we), 32'd0);
        check("rst.be",    32'(dmem_be), 32'd0);
        check("rst.addr",  dmem_addr, 32'h0);
        check("rst.wdata", dmem_wdata, 32'h0);
        check("rst.done",  32'(done), 32'd0);
        check("rst.wb",    wb_data, 32'h0);
        check("rst.mis",   32'(misalign), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Valid without read or write must be ignored.
        ex_valid = 1'b1;
        @(posedge clk); #1; ex_valid = 1'b0;
        @(negedge clk);
        check("nop.ready", 32'(ex_ready), 32'd1);
        check("nop.req",   32'(dmem_req), 32'd0);

        //     tag    rd    wr    f3      addr          sdata         rdata         dly exp_addr     be       wdata         wb
        mem_op("sw",  1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h1234_5678, 32'h0,        1, 32'h0000_0104, 4'b1111, 32'h1234_5678, 32'h0);
        mem_op("sb",  1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0,        0, 32'h0000_0100, 4'b1000, 32'hAB00_0000, 32'h0);
        mem_op("lb",  1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0,         32'h0080_0000, 0, 32'h0,        4'b0100, 32'h0,         32'hFFFF_FF80);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0002, 32'h0,         32'h0080_0000, 0, 32'h0,        4'b0100, 32'h0,         32'h0000_0080);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'hBEEF_0000, 1, 32'h0,        4'b1100, 32'h0,         32'h0000_BEEF);
        mem_op("sh",  1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_5A5A, 32'h0,        0, 32'h0000_0100, 4'b1100, 32'h5A5A_0000, 32'h0000_BEEF);
        mem_op("lh",  1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'h8001_0000, 0, 32'h0000_0010, 4'b1100, 32'h0,         32'hFFFF_8001);
        mem_op("rw",  1'b1, 1'b1, 3'b000, 32'h0000_0021, 32'h0000_0077, 32'h0,        0, 32'h0000_0020, 4'b0010, 32'h0000_7700, 32'hFFFF_8001);
        mem_op("f3b", 1'b0, 1'b1, 3'b011, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,        0, 32'h0000_0010, 4'b0000, 32'hA5A5_A5A5, 32'hFFFF_8001);
        // Slow LW immediately followed by an op at the earliest legal edge.
        mem_op("lw3", 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 3, 32'h0000_0200, 4'b1111, 32'h0,         32'hDEAD_BEEF);
        mem_op("b2b", 1'b1, 1'b0, 3'b101, 32'h0000_0300, 32'h0,         32'h1234_F00D, 0, 32'h0000_0300, 4'b0011, 32'h0,         32'h0000_F00D);

`ifdef LSU_MISALIGN_TRAP_EN
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_0006;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        @(negedge clk);
        check("mis.req",  32'(dmem_req), 32'd0);
        check("mis.flag", 32'(misalign), 32'd1);
        check("mis.done", 32'(done), 32'd1);
        check("mis.wb",   wb_data, 32'h0000_F00D);
        @(negedge clk);
        check("mis.flag_1cyc", 32'(misalign), 32'd0);
        check("mis.done_1cyc", 32'(done), 32'd0);
        check("mis.ready",     32'(ex_ready), 32'd1);
`else
        mem_op("lw6", 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0, 32'h0000_0004, 4'b1111, 32'h0, 32'hCAFE_F00D);
        mem_op("lh3", 1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h8001_0000, 0, 32'h0,         4'b1100, 32'h0, 32'hFFFF_8001);
        check("mis.tied", 32'(misalign), 32'd0);
`endif

        // Reset while waiting for ack, then a stray ack in IDLE.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_0400;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        @(negedge clk);
        check("rstx.req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstx.req",   32'(dmem_req), 32'd0);
        check("rstx.ready", 32'(ex_ready), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check("rstx.no_done", 32'(done), 32'd0);
        check("rstx.idle",    32'(ex_ready), 32'd1);
        check("rstx.wb",      wb_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
